// File: rtl/lcg_stim_if.sv
// Stimulus valid/ready channel between the LCG generator and the consumer.
interface lcg_stim_if #(
    parameter int IN_W = 262
) ();
    logic [IN_W-1:0] stim_data;
    logic            stim_valid;
    logic            stim_ready;

    modport master (
        output stim_data,
        output stim_valid,
        input  stim_ready
    );

    modport slave (
        input  stim_data,
        input  stim_valid,
        output stim_ready
    );
endinterface

// File: rtl/lcg_stim_gen.sv
// LCG stimulus generator: streams IN_W-bit pseudo-random vectors per run.
// Optional response MISR is built only when LCG_STIM_MISR_EN is defined.
module lcg_stim_gen #(
    parameter int          IN_W         = 262,
    parameter int          CAP_W        = 330,
    parameter logic [31:0] DEFAULT_SEED = 32'hBDC1_4F1F
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              abort,
    input  logic [31:0]       seed,
    input  logic [31:0]       num_vec,
    lcg_stim_if.master        stim,
    output logic              busy,
    output logic              done,
    output logic [31:0]       vec_idx,
    output logic [31:0]       rng_state,
    input  logic [CAP_W-1:0]  resp_data,
    input  logic              resp_valid,
    output logic [31:0]       signature
);
    localparam int NW = (IN_W + 31) / 32;
    localparam int WW = (NW > 1) ? $clog2(NW) : 1;

    typedef enum logic [1:0] {
        IDLE,
        FILL,
        PRESENT,
        DONE
    } state_t;

    state_t            state_q;
    state_t            state_d;
    logic [NW*32-1:0]  shadow;
    logic [NW*32-1:0]  fill_vec;
    logic [WW-1:0]     widx;
    logic [31:0]       num_q;
    logic [31:0]       rng_next;
    logic              last_word;
    logic              last_vec;
    logic              start_ok;
    logic              unused_pad;

    assign rng_next  = rng_state * 32'h41C6_4E6D + 32'h0000_3039;
    assign last_word = (widx == WW'(NW - 1));
    assign last_vec  = ({1'b0, vec_idx} + 33'd1) == {1'b0, num_q};
    assign start_ok  = start && !abort &&
                       (state_q == IDLE || state_q == DONE);

    assign stim.stim_valid = (state_q == PRESENT);
    assign busy = (state_q == FILL) || (state_q == PRESENT);
    assign done = (state_q == DONE);

    // Shadow with the word produced this cycle merged in; copied out on the last fill.
    always_comb begin
        fill_vec = shadow;
        fill_vec[{widx, 5'd0} +: 32] = rng_next;
    end

    assign unused_pad = ^fill_vec;

    always_ff @(posedge clk) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE, DONE: begin
                if (start) state_d = (num_vec == 32'd0) ? DONE : FILL;
            end
            FILL: begin
                if (last_word) state_d = PRESENT;
            end
            PRESENT: begin
                if (stim.stim_ready) state_d = last_vec ? DONE : FILL;
            end
            default: state_d = IDLE;
        endcase
        if (abort) state_d = IDLE;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rng_state      <= DEFAULT_SEED;
            vec_idx        <= '0;
            num_q          <= '0;
            widx           <= '0;
            shadow         <= '0;
            stim.stim_data <= '0;
        end else if (!abort) begin
            unique case (state_q)
                IDLE, DONE: begin
                    if (start) begin
                        rng_state <= seed;
                        vec_idx   <= '0;
                        num_q     <= num_vec;
                        widx      <= '0;
                    end
                end
                FILL: begin
                    rng_state <= rng_next;
                    shadow    <= fill_vec;
                    if (last_word) begin
                        widx           <= '0;
                        stim.stim_data <= fill_vec[IN_W-1:0];
                    end else begin
                        widx <= widx + WW'(1);
                    end
                end
                PRESENT: begin
                    if (stim.stim_ready && vec_idx != '1)
                        vec_idx <= vec_idx + 32'd1;
                end
                default: ;
            endcase
        end
    end

`ifdef LCG_STIM_MISR_EN
    localparam int CW = (CAP_W + 31) / 32;

    logic [CW*32-1:0] resp_pad;
    logic [31:0]      fold;

    always_comb begin
        resp_pad = '0;
        resp_pad[CAP_W-1:0] = resp_data;
        fold = '0;
        for (int i = 0; i < CW; i++)
            fold = fold ^ resp_pad[i*32 +: 32];
    end

    always_ff @(posedge clk) begin
        if (!rst_n)
            signature <= '0;
        else if (start_ok)
            signature <= '0;
        else if (resp_valid)
            signature <= {signature[30:0], 1'b0} ^
                         (signature[31] ? 32'h04C1_1DB7 : 32'h0) ^ fold;
    end
`else
    logic unused_resp;

    assign unused_resp = ^{resp_data, resp_valid, start_ok};
    assign signature   = '0;
`endif
endmodule

// File: tb/tb_lcg_stim_gen.sv
// Directed bench for lcg_stim_gen: 64-bit and 38-bit instances run in lockstep.
module tb_lcg_stim_gen;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst_n, start, abort, resp_valid, rdy;
    logic [31:0]  seed, num_vec;
    logic [329:0] resp_data;
    logic         busy_a, done_a, busy_b, done_b;
    logic [31:0]  idx_a, rng_a, sig_a, idx_b, rng_b, sig_b;

    int checks = 0;
    int errors = 0;

`ifdef LCG_STIM_MISR_EN
    localparam bit MISR = 1'b1;
`else
    localparam bit MISR = 1'b0;
`endif

    lcg_stim_if #(.IN_W(64)) if_a ();
    lcg_stim_if #(.IN_W(38)) if_b ();

    assign if_a.stim_ready = rdy;
    assign if_b.stim_ready = rdy;

    lcg_stim_gen #(.IN_W(64)) dut_a (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .seed(seed), .num_vec(num_vec), .stim(if_a.master),
        .busy(busy_a), .done(done_a), .vec_idx(idx_a), .rng_state(rng_a),
        .resp_data(resp_data), .resp_valid(resp_valid), .signature(sig_a)
    );

    lcg_stim_gen #(.IN_W(38)) dut_b (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
        .seed(seed), .num_vec(num_vec), .stim(if_b.master),
        .busy(busy_b), .done(done_b), .vec_idx(idx_b), .rng_state(rng_b),
        .resp_data(resp_data), .resp_valid(resp_valid), .signature(sig_b)
    );

    typedef struct {
        logic [31:0] seed;
        logic [63:0] exp64;
        logic [37:0] exp38;
        logic [31:0] rng;
    } vec_t;

    vec_t tbl[4];

    function automatic logic [31:0] lcg(input logic [31:0] s);
        return s * 32'h41C64E6D + 32'h00003039;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic start_run(input logic [31:0] s, input logic [31:0] nv);
        seed    = s;
        num_vec = nv;
        start   = 1'b1;
        step();
        start   = 1'b0;
    endtask

    task automatic wait_valid(output int n);
        n = 1;
        while (!if_a.stim_valid && n < 20) begin
            step();
            n++;
        end
    endtask

    task automatic chk_reset();
        chk("rst_valid", {if_a.stim_valid, if_b.stim_valid}, 0);
        chk("rst_busy", {busy_a, busy_b}, 0);
        chk("rst_done", {done_a, done_b}, 0);
        chk("rst_idx", {idx_a, idx_b}, 0);
        chk("rst_rng", {rng_a, rng_b}, {2{32'hBDC14F1F}});
        chk("rst_data64", if_a.stim_data, 0);
        chk("rst_data38", {26'd0, if_b.stim_data}, 0);
        chk("rst_sig", {sig_a, sig_b}, 0);
    endtask

    task automatic misr_pair();
        resp_data  = 330'd1;
        resp_valid = 1'b1;
        step();
        chk("sig_1", {sig_a, sig_b}, MISR ? {2{32'd1}} : 64'd0);
        step();
        chk("sig_3", {sig_a, sig_b}, MISR ? {2{32'd3}} : 64'd0);
        resp_valid = 1'b0;
    endtask

    initial begin
        int n;
        logic [31:0] st, w1, w2;
        logic [63:0] v1;
        logic [31:0] r_hold;

        tbl[0] = '{32'h0, 64'hD3DC167E_00003039, 38'h3E_00003039, 32'hD3DC167E};
        tbl[1] = '{32'h1, 64'h0, 38'h0, 32'h0};
        tbl[2] = '{32'hDEADBEEF, 64'h0, 38'h0, 32'h0};
        tbl[3] = '{32'hFFFFFFFF, 64'h0, 38'h0, 32'h0};
        for (int i = 1; i < 4; i++) begin
            w1 = lcg(tbl[i].seed);
            w2 = lcg(w1);
            tbl[i].exp64 = {w2, w1};
            tbl[i].exp38 = {w2[5:0], w1};
            tbl[i].rng   = w2;
        end

        rst_n = 1'b0; start = 1'b0; abort = 1'b0; rdy = 1'b1;
        seed = '0; num_vec = '0; resp_valid = 1'b0; resp_data = '0;
        step();
        step();
        chk_reset();
        rst_n = 1'b1;
        step();

        // Single-vector runs with the consumer always ready
        for (int i = 0; i < 4; i++) begin
            start_run(tbl[i].seed, 32'd1);
            chk($sformatf("busy_%0d", i), busy_a, 1);
            wait_valid(n);
            chk($sformatf("lat_%0d", i), n, 3);
            chk($sformatf("data64_%0d", i), if_a.stim_data, tbl[i].exp64);
            chk($sformatf("data38_%0d", i), {26'd0, if_b.stim_data},
                {26'd0, tbl[i].exp38});
            step();
            chk($sformatf("done_%0d", i), {done_a, done_b, busy_a}, 3'b110);
            chk($sformatf("idx_%0d", i), {idx_a, idx_b}, {32'd1, 32'd1});
            chk($sformatf("rng_%0d", i), rng_a, tbl[i].rng);
        end

        // Three back-to-back vectors: period NW+1 and state continuity
        st = 32'h12345678;
        start_run(st, 32'd3);
        wait_valid(n);
        for (int k = 0; k < 3; k++) begin
            w1 = lcg(st);
            w2 = lcg(w1);
            st = w2;
            if (k > 0) chk($sformatf("period_%0d", k), n, 3);
            chk($sformatf("multi64_%0d", k), if_a.stim_data, {w2, w1});
            step();
            chk($sformatf("multi_idx_%0d", k), idx_a, k + 1);
            if (k < 2) wait_valid(n);
        end
        chk("multi_done", {done_a, if_a.stim_valid}, 2'b10);

        // Backpressure, with a start pulse while busy that must be ignored
        rdy = 1'b0;
        start_run(32'h0, 32'd1);
        wait_valid(n);
        r_hold = rng_a;
        for (int c = 0; c < 10; c++) begin
            if (c == 4) begin
                seed  = 32'hCAFEF00D;
                start = 1'b1;
            end
            step();
            start = 1'b0;
            chk($sformatf("hold_%0d", c),
                {if_a.stim_data, 32'd0} | {32'd0, rng_a},
                {tbl[0].exp64, 32'd0} | {32'd0, r_hold});
            chk($sformatf("hold_v_%0d", c), {if_a.stim_valid, idx_a}, {1'b1, 32'd0});
        end
        rdy = 1'b1;
        step();
        chk("bp_accept", {done_a, idx_a}, {1'b1, 32'd1});

        // Zero-length run goes straight to DONE; MISR cleared by each start
        start_run(32'h55, 32'd0);
        chk("nv0_done", {done_a, done_b, busy_a}, 3'b110);
        misr_pair();
        start_run(32'h66, 32'd0);
        chk("sig_clear", {sig_a, sig_b}, 0);
        misr_pair();
        for (int c = 0; c < 4; c++) begin
            step();
            chk($sformatf("nv0_novalid_%0d", c), if_a.stim_valid, 0);
        end

        // Abort in the second fill cycle of vector 2
        st = 32'hA5A5_0001;
        start_run(st, 32'd3);
        wait_valid(n);
        v1 = if_a.stim_data;
        chk("ab_v1", v1, {lcg(lcg(st)), lcg(st)});
        step();
        step();
        chk("ab_in_fill", {busy_a, if_a.stim_valid}, 2'b10);
        abort = 1'b1;
        step();
        abort = 1'b0;
        chk("ab_idle", {busy_a, done_a, if_a.stim_valid}, 3'b000);
        chk("ab_data", if_a.stim_data, v1);
        chk("ab_idx", idx_a, 1);
        chk("ab_rng", rng_a, lcg(lcg(lcg(st))));
        start_run(st, 32'd1);
        wait_valid(n);
        chk("ab_repro", if_a.stim_data, v1);
        step();

        // Reset mid-fill overrides start/abort and drops the partial shadow
        start_run(32'h0BAD_F00D, 32'd2);
        step();
        rst_n = 1'b0;
        start = 1'b1;
        abort = 1'b1;
        step();
        start = 1'b0;
        abort = 1'b0;
        chk_reset();
        rst_n = 1'b1;
        step();
        start_run(32'h0, 32'd1);
        wait_valid(n);
        chk("post_rst_data", if_a.stim_data, tbl[0].exp64);
        chk("post_rst_lat", n, 3);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/lcg_stim_gen.md
LCG_STIM_GEN -- requirements
Module: lcg_stim_gen

Interface
REQ-001 The block SHALL have parameter IN_W, default 262, meaning the stimulus vector width in bits (1..1024).
REQ-002 The block SHALL have parameter CAP_W, default 330, meaning the response capture width in bits (1..1024).
REQ-003 The block SHALL have parameter DEFAULT_SEED, default 32'hBDC1_4F1F, meaning the LCG state loaded at reset.
REQ-004 The block SHALL have port clk  input  1  single clock; all logic on the rising edge.
REQ-005 The block SHALL have port rst_n  input  1  reset, synchronous and active-low.
REQ-006 The block SHALL have port start  input  1  one-cycle pulse; loads seed and begins a run.
REQ-007 The block SHALL have port abort  input  1  terminates the run, returns to IDLE.
REQ-008 The block SHALL have port seed  input  32  LCG seed, sampled with start.
REQ-009 The block SHALL have port num_vec  input  32  vectors per run, sampled with start.
REQ-010 The block SHALL have ports stim_data  output  IN_W, stim_valid  output  1, and stim_ready  input  1, forming the stimulus valid/ready channel.
REQ-011 The block SHALL have ports busy  output  1, done  output  1, vec_idx  output  32 (accepted-vector count) and rng_state  output  32 (current LCG state).
REQ-012 The block SHALL have ports resp_data  input  CAP_W, resp_valid  input  1, and signature  output  32.

Function
REQ-013 Each LCG step SHALL compute state = state*32'h41C64E6D + 32'h3039, modulo 2^32.
REQ-014 A vector SHALL be NW = ceil(IN_W/32) words, with word j = result of step j placed at bits [32j+31:32j], LSB word first.
REQ-015 The final word of a vector SHALL keep only its low IN_W-32*(NW-1) bits.
REQ-016 The FSM SHALL have states IDLE, FILL, PRESENT and DONE.
REQ-017 In IDLE or DONE, start SHALL load rng_state=seed, vec_idx=0 and done=0, and move to FILL, or to DONE if num_vec=0.
REQ-018 FILL SHALL perform one LCG step per cycle into a shadow register, NW cycles in total.
REQ-019 On the last FILL cycle, the shadow contents SHALL be copied to stim_data atomically, with stim_valid=1 from the next cycle and state=PRESENT.
REQ-020 stim_data SHALL change only at that copy; it SHALL hold its value otherwise, including across runs and after abort.
REQ-021 In PRESENT, stim_valid&&stim_ready SHALL increment vec_idx, then go to DONE if vec_idx+1==num_vec, else to FILL.
REQ-022 While stim_ready=0 in PRESENT, stim_data, stim_valid and rng_state SHALL all stay stable.
REQ-023 When no abort is asserted, the minimum vector period SHALL be NW+1 cycles.
REQ-024 start while busy SHALL be ignored.
REQ-025 abort SHALL have priority over start and the handshake; the next state SHALL be IDLE, with stim_valid=0, done=0, and rng_state and vec_idx retained.
REQ-026 busy SHALL be 1 in FILL and PRESENT.
REQ-027 done SHALL be 1 in DONE and hold until start or abort.
REQ-028 vec_idx SHALL saturate at 32'hFFFFFFFF.

Reset
REQ-029 With rst_n=0 at a clock edge, the state SHALL become IDLE, with rng_state=DEFAULT_SEED, stim_data=0, stim_valid=0, busy=0, done=0, vec_idx=0 and signature=0.
REQ-030 Reset SHALL override start and abort, and reset mid-run SHALL discard any partially filled shadow.

Configuration
REQ-031 With macro LCG_STIM_MISR_EN defined, each resp_valid cycle SHALL update signature = (sig<<1) ^ (sig[31] ? 32'h04C11DB7 : 0) ^ F.
REQ-032 F SHALL be the XOR of all 32-bit chunks of resp_data, with the last chunk zero-padded.
REQ-033 With LCG_STIM_MISR_EN defined, start SHALL clear signature to 0.
REQ-034 Without LCG_STIM_MISR_EN, signature SHALL be held at 0, resp_data and resp_valid SHALL be ignored, and no MISR logic SHALL be instantiated.

Verification
REQ-035 IN_W=64, seed=0, num_vec=1, stim_ready=1 -> stim_valid rises 3 cycles after start, stim_data=64'hD3DC167E_00003039, done=1 the cycle after the handshake, and vec_idx=1.
REQ-036 IN_W=38, seed=0, num_vec=1 -> stim_data=38'h3E_00003039.
REQ-037 stim_ready=0 for 10 cycles in PRESENT -> stim_data, stim_valid and rng_state are constant, and the vector is accepted on the first stim_ready=1 cycle.
REQ-038 num_vec=0 -> done=1 one cycle after start, and stim_valid is never asserted.
REQ-039 abort during the second FILL cycle of vector 2 -> IDLE next cycle, stim_valid=0, stim_data=vector 1, and a following start with the same seed reproduces vector 1.
REQ-040 With LCG_STIM_MISR_EN, after start, two resp_valid cycles with resp_data=1 -> signature=1 then 3; without the macro, signature=0.
